// File: rtl/cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_exc_ctrl -- Coprocessor-0 exception/interrupt controller (Memory stage)
//
// Arbitrates hardware interrupts against the synchronous exception code that
// travels down the pipe, raises Req to flush/freeze the pipeline, and keeps
// SR(12), Cause(13), EPC(14) and PRId(15). Serves mfc0 / mtc0 / eret.
//
// Optional feature: define CP0_BADVADDR_EN to add the BadAddr_M input and the
// BadVAddr(8) register, captured on address-error exceptions (AdEL/AdES).
// ---------------------------------------------------------------------------
module cp0_exc_ctrl #(
   parameter logic [31:0] PRID_VALUE = 32'h2022_1107,
   parameter logic [31:0] SR_WMASK   = 32'h0000_FC03
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] Din,
   input  logic        WE,
   input  logic [31:0] PC_M,
   input  logic        Delay_M,
   input  logic [4:0]  ExcCode_M,
   input  logic        EXLClr,
   input  logic [5:0]  HWInt,
`ifdef CP0_BADVADDR_EN
   input  logic [31:0] BadAddr_M,
`endif
   output logic        Req,
   output logic [31:0] EPC_o,
   output logic [31:0] Dout
);

   // Register numbers served by mfc0/mtc0
   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_SR       = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_PRID     = 5'd15;

   // SR bits that physically exist: IM[15:10], EXL[1], IE[0]
   localparam logic [31:0] SR_KEEP     = 32'h0000_FC03;
   localparam logic [31:0] WORD_ALIGN  = 32'hFFFF_FFFC;

   // Address-error exception codes (AdEL / AdES)
   localparam logic [4:0] EXC_ADEL     = 5'd4;
   localparam logic [4:0] EXC_ADES     = 5'd5;

   // Architectural state
   logic [31:0] sr_q, sr_d;
   logic        cause_bd_q, cause_bd_d;
   logic [5:0]  cause_ip_q, cause_ip_d;
   logic [4:0]  cause_exc_q, cause_exc_d;
   logic [31:0] epc_q, epc_d;
`ifdef CP0_BADVADDR_EN
   logic [31:0] badvaddr_q, badvaddr_d;
`endif

   // SR field views
   logic        sr_ie;
   logic        sr_exl;
   logic [5:0]  sr_im;

   // Request terms and helpers
   logic        int_req;
   logic        exc_req;
   logic [31:0] cause_rd;
   logic [31:0] sr_merged;
   logic [31:0] pc_aligned;

   assign sr_ie  = sr_q[0];
   assign sr_exl = sr_q[1];
   assign sr_im  = sr_q[15:10];

   // Cause as seen by mfc0: BD[31], IP[15:10], ExcCode[6:2], rest zero
   assign cause_rd   = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
   // SR after an mtc0: only writable bits change, unimplemented bits stay zero
   assign sr_merged  = ((sr_q & ~SR_WMASK) | (Din & SR_WMASK)) & SR_KEEP;
   assign pc_aligned = PC_M & WORD_ALIGN;

   // Request arbitration: interrupt beats exception, nothing taken while EXL=1
   always_comb begin
      int_req = sr_ie & ~sr_exl & (|(HWInt & sr_im));
      exc_req = ~sr_exl & (ExcCode_M != 5'd0);
      Req     = ~reset & (int_req | exc_req);
   end

   // Next-state computation for SR, Cause and EPC
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      sr_d        = sr_q;
      cause_bd_d  = cause_bd_q;
      cause_exc_d = cause_exc_q;
      epc_d       = epc_q;
      // Pending-interrupt bits track the lines every cycle, independent of EXL
      cause_ip_d  = HWInt;

      if (Req) begin
         // A taken request flushes the mtc0/eret in M, so its write is dropped
         sr_d[1]     = 1'b1;
         cause_exc_d = int_req ? 5'd0 : ExcCode_M;
         cause_bd_d  = Delay_M;
         epc_d       = Delay_M ? (pc_aligned - 32'd4) : pc_aligned;
      end else begin
         if (WE) begin
            case (A2)
               REG_SR:  sr_d  = sr_merged;
               REG_EPC: epc_d = Din & WORD_ALIGN;
               default: ; // Cause, PRId and unimplemented numbers are read-only
            endcase
         end
         // eret applied after mtc0 so it wins for EXL when both hit SR
         if (EXLClr) begin
            sr_d[1] = 1'b0;
         end
      end
   end

`ifdef CP0_BADVADDR_EN
   // BadVAddr captures the faulting address on an address-error exception
   always_comb begin
      badvaddr_d = badvaddr_q;
      if (exc_req && !int_req && (ExcCode_M == EXC_ADEL || ExcCode_M == EXC_ADES)) begin
         badvaddr_d = BadAddr_M;
      end
   end
`endif

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (reset) begin
         sr_q        <= 32'd0;
         cause_bd_q  <= 1'b0;
         cause_ip_q  <= 6'd0;
         cause_exc_q <= 5'd0;
         epc_q       <= 32'd0;
      end else begin
         sr_q        <= sr_d;
         cause_bd_q  <= cause_bd_d;
         cause_ip_q  <= cause_ip_d;
         cause_exc_q <= cause_exc_d;
         epc_q       <= epc_d;
      end
   end

`ifdef CP0_BADVADDR_EN
   // BadVAddr register, cleared by reset and not writable by mtc0
   always_ff @(posedge clk) begin
      if (reset) begin
         badvaddr_q <= 32'd0;
      end else begin
         badvaddr_q <= badvaddr_d;
      end
   end
`endif

   // mfc0 read mux: combinational, no bypass of a same-cycle mtc0
   always_comb begin
      Dout = 32'd0;
      case (A1)
         REG_SR:       Dout = sr_q;
         REG_CAUSE:    Dout = cause_rd;
         REG_EPC:      Dout = epc_q;
         REG_PRID:     Dout = PRID_VALUE;
`ifdef CP0_BADVADDR_EN
         REG_BADVADDR: Dout = badvaddr_q;
`else
         REG_BADVADDR: Dout = 32'd0;
`endif
         default:      Dout = 32'd0;
      endcase
   end

   assign EPC_o = epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cp0_exc_ctrl -- directed self-checking bench for cp0_exc_ctrl.
// Inputs are driven 1 time unit after a rising edge; outputs are compared
// 1 time unit later, well away from the next edge. Build with or without
// CP0_BADVADDR_EN; the BadVAddr expectation follows the macro.
// ---------------------------------------------------------------------------
module tb_cp0_exc_ctrl;

   localparam logic [31:0] PRID = 32'h2022_1107;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  A1, A2;
   logic [31:0] Din;
   logic        WE;
   logic [31:0] PC_M;
   logic        Delay_M;
   logic [4:0]  ExcCode_M;
   logic        EXLClr;
   logic [5:0]  HWInt;
`ifdef CP0_BADVADDR_EN
   logic [31:0] BadAddr_M;
`endif
   logic        Req;
   logic [31:0] EPC_o;
   logic [31:0] Dout;

   int n_tests = 0;
   int n_fail  = 0;

   cp0_exc_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .A1        (A1),
      .A2        (A2),
      .Din       (Din),
      .WE        (WE),
      .PC_M      (PC_M),
      .Delay_M   (Delay_M),
      .ExcCode_M (ExcCode_M),
      .EXLClr    (EXLClr),
      .HWInt     (HWInt),
`ifdef CP0_BADVADDR_EN
      .BadAddr_M (BadAddr_M),
`endif
      .Req       (Req),
      .EPC_o     (EPC_o),
      .Dout      (Dout)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expected value
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock, land 1 unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read a CP0 register through the combinational mfc0 port
   task automatic rd(input string tag, input logic [4:0] num, input logic [31:0] exp);
      A1 = num;
      #1;
      check(tag, Dout, exp);
   endtask

   task automatic settle_req(input string tag, input logic exp);
      #1;
      check(tag, {31'd0, Req}, {31'd0, exp});
   endtask

   initial begin
      reset = 1'b1; A1 = 5'd0; A2 = 5'd0; Din = 32'd0; WE = 1'b0;
      PC_M = 32'd0; Delay_M = 1'b0; ExcCode_M = 5'd12; EXLClr = 1'b0; HWInt = 6'h3F;
`ifdef CP0_BADVADDR_EN
      BadAddr_M = 32'd0;
`endif
      // Reset: Req held low even with an exception code and all lines high
      tick();
      tick();
      settle_req("req_in_reset", 1'b0);
      check("epc_after_reset", EPC_o, 32'd0);

      // Released: IE=0 masks interrupts; register file at reset values
      reset = 1'b0; ExcCode_M = 5'd0;
      settle_req("req_ie_off", 1'b0);
      rd("sr_reset",    5'd12, 32'd0);
      rd("cause_reset", 5'd13, 32'd0);
      rd("epc_reset",   5'd14, 32'd0);
      rd("prid",        5'd15, PRID);
      rd("reg8_reset",  5'd8,  32'd0);
      rd("reg3_zero",   5'd3,  32'd0);
      HWInt = 6'd0;

      // mtc0 SR with all ones: only IM/EXL/IE stick
      WE = 1'b1; A2 = 5'd12; Din = 32'hFFFF_FFFF;
      tick();
      rd("sr_wmask", 5'd12, 32'h0000_FC03);
      // mtc0 to Cause is ignored
      A2 = 5'd13;
      tick();
      rd("cause_ro", 5'd13, 32'd0);
      // Clear EXL by mtc0 so requests can be taken
      A2 = 5'd12; Din = 32'hFFFF_FFFD;
      tick();
      WE = 1'b0;
      rd("sr_exl_clr", 5'd12, 32'h0000_FC01);

      // Interrupt on HWInt[2]
      HWInt = 6'b000100; PC_M = 32'h0000_1000; Delay_M = 1'b0;
      settle_req("req_int2", 1'b1);
      tick();
      rd("cause_int2", 5'd13, 32'h0000_1000);
      rd("sr_exl_set", 5'd12, 32'h0000_FC03);
      check("epc_int2", EPC_o, 32'h0000_1000);

      // eret with lines low
      HWInt = 6'd0; EXLClr = 1'b1;
      settle_req("req_eret_exl", 1'b0);
      tick();
      EXLClr = 1'b0;
      rd("sr_after_eret", 5'd12, 32'h0000_FC01);

      // Overflow in a delay slot
      ExcCode_M = 5'd12; Delay_M = 1'b1; PC_M = 32'h0000_3010;
      settle_req("req_ov", 1'b1);
      tick();
      ExcCode_M = 5'd0; Delay_M = 1'b0;
      rd("cause_ov_bd", 5'd13, 32'h8000_0030);
      check("epc_ov_bd", EPC_o, 32'h0000_300C);

      // Interrupt and exception together: interrupt wins
      EXLClr = 1'b1;
      tick();
      EXLClr = 1'b0;
      HWInt = 6'b000001; ExcCode_M = 5'd10; PC_M = 32'h0000_2000;
      settle_req("req_int_vs_exc", 1'b1);
      tick();
      rd("cause_int_prio", 5'd13, 32'h0000_0400);
      check("epc_int_prio", EPC_o, 32'h0000_2000);

      // Nested: EXL=1 blocks a new exception
      HWInt = 6'd0; ExcCode_M = 5'd4; PC_M = 32'h0000_4444;
      settle_req("req_nested_blocked", 1'b0);
      tick();
      check("epc_nested_hold", EPC_o, 32'h0000_2000);
      ExcCode_M = 5'd0;

      // mtc0 SR together with eret: eret wins EXL, other bits from Din
      WE = 1'b1; A2 = 5'd12; Din = 32'h0000_0403; EXLClr = 1'b1;
      tick();
      WE = 1'b0; EXLClr = 1'b0;
      rd("sr_we_eret", 5'd12, 32'h0000_0401);

      // Req beats a same-cycle mtc0 EPC
      HWInt = 6'b000001; PC_M = 32'h0000_5008;
      WE = 1'b1; A2 = 5'd14; Din = 32'h0000_1234;
      settle_req("req_vs_mtc0", 1'b1);
      tick();
      WE = 1'b0;
      check("epc_req_beats_we", EPC_o, 32'h0000_5008);
      settle_req("req_held_exl", 1'b0);
      // eret with the interrupt still asserted re-raises Req
      EXLClr = 1'b1;
      settle_req("req_eret_cycle", 1'b0);
      tick();
      EXLClr = 1'b0;
      settle_req("req_reraise", 1'b1);
      rd("sr_reraise", 5'd12, 32'h0000_0401);
      HWInt = 6'd0;
      settle_req("req_line_drop", 1'b0);

      // mtc0 EPC aligns the address; no same-cycle bypass
      WE = 1'b1; A2 = 5'd14; Din = 32'h0000_ABCF;
      rd("epc_no_bypass", 5'd14, 32'h0000_5008);
      tick();
      WE = 1'b0;
      check("epc_mtc0_align", EPC_o, 32'h0000_ABCC);

      // Address error (AdES)
      ExcCode_M = 5'd5; PC_M = 32'h0000_6000;
`ifdef CP0_BADVADDR_EN
      BadAddr_M = 32'h0000_7F01;
`endif
      settle_req("req_ades", 1'b1);
      tick();
      ExcCode_M = 5'd0;
      rd("cause_ades", 5'd13, 32'h0000_0014);
`ifdef CP0_BADVADDR_EN
      rd("badvaddr", 5'd8, 32'h0000_7F01);
`else
      rd("badvaddr", 5'd8, 32'd0);
`endif

      // IP follows the lines while EXL=1, without taking a request
      HWInt = 6'b100000;
      settle_req("req_ip_masked", 1'b0);
      tick();
      rd("cause_ip_track", 5'd13, 32'h0000_8014);
      HWInt = 6'd0;

      // Mid-run reset clears state
      reset = 1'b1;
      tick();
      check("epc_rereset", EPC_o, 32'd0);
      rd("sr_rereset", 5'd12, 32'd0);
      rd("cause_rereset", 5'd13, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller in the Memory stage of the pipelined MIPS core.
- Collects the exception code and delay-slot flag from the Execute/Memory pipeline, plus the hardware interrupt lines.
- Arbitrates between them, raises Req to flush and freeze the pipeline (HI/LO writes included), and records SR/Cause/EPC.
- Serves mfc0/mtc0/eret.

Parameters:
- PRID_VALUE, 32'h2022_1107, constant returned on reads of register 15 (PRId).
- SR_WMASK, 32'h0000_FC03, SR bits writable by mtc0 (IM[15:10], EXL[1], IE[0]).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- A1  in  5  mfc0 read register number
- A2  in  5  mtc0 write register number
- Din  in  32  mtc0 write data (already forwarded)
- WE  in  1  mtc0 write enable
- PC_M  in  32  PC of the instruction currently in M
- Delay_M  in  1  M instruction is in a branch delay slot
- ExcCode_M  in  5  exception code carried down the pipe (0 = none)
- EXLClr  in  1  eret in M
- HWInt  in  6  external interrupt lines [5:0]
- Req  out  1  exception/interrupt taken this cycle
- EPC_o  out  32  current EPC (eret target)
- Dout  out  32  mfc0 read data

Behaviour:
- Registers:
  - SR(12) keeps IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause(13) keeps BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC(14) is a full 32-bit register.
  - PRId(15) returns PRID_VALUE.
  - Any other A1 reads 0.
- Reset: on a posedge with reset=1, SR, Cause and EPC clear to 0. While reset=1, Req=0. EPC_o=0 and Dout=0 (for A1 != 15) after the reset edge.
- Request logic (combinational):
  - IntReq = IE & ~EXL & |(HWInt & IM).
  - ExcReq = ~EXL & (ExcCode_M != 0).
  - Req = ~reset & (IntReq | ExcReq).
  - Interrupt has priority over a synchronous exception.
- On a posedge with Req=1, all of the following update in the same edge:
  - EXL <= 1.
  - Cause.ExcCode <= IntReq ? 0 : ExcCode_M.
  - Cause.BD <= Delay_M.
  - EPC <= Delay_M ? {PC_M[31:2],2'b00} - 4 : {PC_M[31:2],2'b00}.
- Cause.IP <= HWInt every non-reset cycle, regardless of Req or EXL.
- mtc0:
  - A posedge with WE=1 and Req=0 writes the selected register.
  - SR takes the SR_WMASK bits only.
  - EPC takes {Din[31:2],2'b00}.
  - Writes to Cause, PRId or any other number are ignored.
- eret: a posedge with EXLClr=1 and Req=0 clears EXL.
- Simultaneous events:
  - Req beats WE and EXLClr; the mtc0/eret instruction is flushed and its write is dropped.
  - WE to SR together with EXLClr: EXLClr wins for the EXL bit; the other bits take Din.
- Reads:
  - Dout is combinational from A1 with no bypass; a same-cycle mtc0 becomes visible next cycle.
  - EPC_o is the registered EPC.
- Nested requests: while EXL=1, no request is taken. A pending ExcCode or an unmasked HWInt waits until EXL clears; the interrupt stays level-sensitive.
- Latency: Req is asserted in the same cycle the cause is present. The state update lands on the next edge.

Optional Feature:
- Macro CP0_BADVADDR_EN.
- When defined:
  - Adds input BadAddr_M [31:0] (address computed by Execute).
  - Adds register 8 (BadVAddr).
  - On a posedge with ExcReq=1, IntReq=0 and ExcCode_M in {4,5} (AdEL/AdES), BadVAddr <= BadAddr_M.
  - Reads of A1=8 return it; it is not writable by mtc0 and is reset to 0.
- When undefined: no port, and A1=8 reads 0.

Test Plan:
- Reset, then read A1=12/13/14/15 -> Dout = 0, 0, 0, PRID_VALUE; Req=0 even with HWInt=6'h3F.
- mtc0 SR Din=32'hFFFF_FFFF -> SR reads 32'h0000_FC03. Then HWInt=6'b000100 -> Req=1 same cycle. Next cycle: Cause=32'h0000_1000, EXL=1, EPC=PC_M.
- ExcCode_M=12 (Ov), Delay_M=1, PC_M=32'h0000_3010, SR.EXL=0 -> Req=1. Next: Cause=32'h8000_0030 (IP=0), EPC=32'h0000_300C.
- Same cycle HWInt[0]=1 (IM[10]=1, IE=1) and ExcCode_M=10 -> Cause.ExcCode=0, interrupt taken. With EXL=1, a new ExcCode_M=4 -> Req=0, EPC unchanged.
- Req=1 with WE=1, A2=14, Din=32'h1234 in the same cycle -> EPC gets the exception PC, not 32'h1234. EXLClr alone next -> EXL=0, and a still-asserted interrupt re-raises Req.
- With CP0_BADVADDR_EN: ExcCode_M=5, BadAddr_M=32'h0000_7F01 -> A1=8 reads 32'h0000_7F01. Without the macro: A1=8 reads 0.
